// File: rtl/keypad_pkg.sv
// keypad_pkg: width and key-index helpers shared by the keypad scanner, its bus and event FIFO.
// An event record is packed as {press, code[KW-1:0]}, so it is evt_w() bits wide.
package keypad_pkg;
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int key_w(input int rows, input int cols);
        return cw(rows * cols);
    endfunction
    function automatic int evt_w(input int rows, input int cols);
        return key_w(rows, cols) + 1;
    endfunction
    function automatic int key_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction
    function automatic int key_row(input int k, input int cols);
        return k / cols;
    endfunction
    function automatic int key_col(input int k, input int cols);
        return k % cols;
    endfunction
endpackage

// File: rtl/keypad_matrix_scan_if.sv
// keypad_matrix_scan_if: keypad pins, debounced level map and press/release event stream.
interface keypad_matrix_scan_if
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 3
);
    localparam int KW = key_w(ROWS, COLS);
    logic [COLS-1:0]      keypadc;
    logic [ROWS-1:0]      keypadr;
    logic [ROWS*COLS-1:0] pressed;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [KW-1:0]        evt_code;
    logic                 evt_press;
    modport master (
        input  keypadc, evt_ready,
        output keypadr, pressed, evt_valid, evt_code, evt_press
    );
    modport slave (
        output keypadc, evt_ready,
        input  keypadr, pressed, evt_valid, evt_code, evt_press
    );
endinterface

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: first-word-fall-through event buffer; head reads as zero while empty.
module keypad_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;
    assign valid   = cnt != '0;
    assign full    = cnt[AW];
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd] : '0;
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            if (do_push && !do_pop) cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
        end
endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: row-scans a ROWS x COLS keypad, debounces every key and
// publishes a level map plus a buffered press/release event stream.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 3,
    parameter int SCAN_DIV   = 1024,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    keypad_matrix_scan_if.master bus
);
    localparam int KEYS = ROWS * COLS;
    localparam int KW   = key_w(ROWS, COLS);
    localparam int RW   = cw(ROWS);
    localparam int PW   = cw(SCAN_DIV);
    localparam int DW   = cw(DEBOUNCE + 1);
    typedef struct packed {
        logic          press;
        logic [KW-1:0] code;
    } evt_t;
    logic [COLS-1:0] c_meta, c_sync;
    logic [PW-1:0]   pre;
    logic [RW-1:0]   row;
    logic [DW-1:0]   deb [KEYS];
    logic [KEYS-1:0] pressed, elig, win;
    logic            tick, full, space, found, commit;
    evt_t            push_evt, head;
    assign tick   = en && pre == PW'(SCAN_DIV - 1);
    assign space  = !full || (bus.evt_valid && bus.evt_ready);
    assign commit = found && space;
    // Keys are visited in index order, so within the sampled row the lowest column wins.
    always_comb begin
        elig     = '0;
        win      = '0;
        found    = 1'b0;
        push_evt = '0;
        for (int k = 0; k < KEYS; k++)
            elig[k] = tick && row == RW'(key_row(k, COLS)) && c_sync[key_col(k, COLS)] != pressed[k]
                      && deb[k] >= DW'(DEBOUNCE - 1);
        for (int k = 0; k < KEYS; k++)
            if (elig[k] && !found) begin
                win[k]   = 1'b1;
                found    = 1'b1;
                push_evt = '{press: !pressed[k], code: KW'(k)};
            end
    end
    // A blocked eligible key saturates its counter and retries on its row's next tick.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            c_meta  <= '0;
            c_sync  <= '0;
            pre     <= '0;
            row     <= '0;
            pressed <= '0;
            for (int k = 0; k < KEYS; k++) deb[k] <= '0;
        end else begin
            c_meta <= bus.keypadc;
            c_sync <= c_meta;
            if (en) pre <= tick ? '0 : pre + 1'b1;
            if (tick) row <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
            if (commit) pressed <= pressed ^ win;
            for (int k = 0; k < KEYS; k++)
                if (tick && row == RW'(key_row(k, COLS)))
                    deb[k] <= ((commit && win[k]) || c_sync[key_col(k, COLS)] == pressed[k]) ? '0 :
                              (deb[k] == DW'(DEBOUNCE)) ? deb[k] : deb[k] + 1'b1;
        end
    keypad_evt_fifo #(.W($bits(evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (commit),
        .din   (push_evt),
        .full  (full),
        .pop   (bus.evt_ready),
        .dout  (head),
        .valid (bus.evt_valid)
    );
    assign bus.keypadr   = en ? ROWS'(1) << row : '0;
    assign bus.pressed   = pressed;
    assign bus.evt_code  = head.code;
    assign bus.evt_press = head.press;
endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: keypad matrix model plus event scoreboard around keypad_matrix_scan.
module tb_keypad_matrix_scan;
    localparam int ROWS = 4, COLS = 3, SCAN_DIV = 4, DEBOUNCE = 3, FIFO_DEPTH = 2;
    localparam int LAT = DEBOUNCE * ROWS * SCAN_DIV + SCAN_DIV + 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] held = '0;
    int          passed = 0, total = 0, cyc = 0, last_pop = 0, prev_pop = 0;
    logic [4:0]  sb [$];
    keypad_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) kif ();
    keypad_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (kif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // A closed key connects its driven row to its column.
    always_comb begin
        kif.keypadc = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (kif.keypadr[r] && held[r*COLS+c]) kif.keypadc[c] = 1'b1;
    end
    always @(negedge clk)
        if (rst_n && kif.evt_valid && kif.evt_ready) begin
            logic [4:0] exp_evt;
            total++;
            if (sb.size() == 0)
                $display("FAIL unexpected_event: got press=%0d code=%0d, none expected", kif.evt_press, kif.evt_code);
            else begin
                exp_evt = sb.pop_front();
                if ({kif.evt_press, kif.evt_code} !== exp_evt)
                    $display("FAIL event: got press=%0d code=%0d expected press=%0d code=%0d",
                             kif.evt_press, kif.evt_code, exp_evt[4], exp_evt[3:0]);
                else passed++;
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    task automatic wait_row0(output bit ok);
        logic [3:0] prev;
        prev = kif.keypadr;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk); #1;
            ok = kif.keypadr == 4'b0001 && prev != 4'b0001;
            prev = kif.keypadr;
        end
    endtask
    task automatic test_reset();
        en = 1'b1;
        kif.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (kif.pressed !== 12'h000 || kif.evt_valid !== 1'b0 || kif.evt_code !== 4'd0 || kif.evt_press !== 1'b0)
            $display("FAIL reset_outputs: got pressed=%h valid=%b code=%0d press=%b expected 000/0/0/0",
                     kif.pressed, kif.evt_valid, kif.evt_code, kif.evt_press);
        else passed++;
        rst_n = 1'b1;
        for (int n = 0; n <= 16; n++) begin
            if (n % 4 == 0) begin
                logic [3:0] exp_r;
                exp_r = 4'b0001 << ((n / 4) % 4);
                total++;
                if (kif.keypadr !== exp_r) $display("FAIL row_scan n=%0d: got %b expected %b", n, kif.keypadr, exp_r);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_single_key();
        int i;
        held[5] = 1'b1;
        sb.push_back({1'b1, 4'd5});
        for (i = 0; i < 100 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (sb.size() != 0 || i > LAT) $display("FAIL press_latency: got %0d cycles expected <= %0d", i, LAT);
        else passed++;
        total++;
        if (kif.pressed !== 12'h020) $display("FAIL press_map: got %h expected 020", kif.pressed);
        else passed++;
        held[5] = 1'b0;
        sb.push_back({1'b0, 4'd5});
        for (i = 0; i < 100 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (sb.size() != 0 || kif.pressed !== 12'h000)
            $display("FAIL release: got pending=%0d map=%h expected 0/000", sb.size(), kif.pressed);
        else passed++;
    endtask
    task automatic test_glitch();
        bit ok;
        wait_row0(ok);
        total++;
        if (!ok) $display("FAIL glitch_align: got no row-0 start expected one");
        else passed++;
        held[0] = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        held[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (kif.pressed !== 12'h000 || kif.evt_valid !== 1'b0)
            $display("FAIL glitch: got map=%h valid=%b expected 000/0", kif.pressed, kif.evt_valid);
        else passed++;
    endtask
    task automatic test_same_row_pair();
        int i;
        held[3] = 1'b1;
        held[4] = 1'b1;
        sb.push_back({1'b1, 4'd3});
        sb.push_back({1'b1, 4'd4});
        for (i = 0; i < 150 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (sb.size() != 0 || last_pop - prev_pop != ROWS * SCAN_DIV)
            $display("FAIL pair_spacing: got pending=%0d gap=%0d expected 0/%0d", sb.size(), last_pop - prev_pop, ROWS * SCAN_DIV);
        else passed++;
        total++;
        if (kif.pressed !== 12'h018) $display("FAIL pair_map: got %h expected 018", kif.pressed);
        else passed++;
        held[3] = 1'b0;
        held[4] = 1'b0;
        sb.push_back({1'b0, 4'd3});
        sb.push_back({1'b0, 4'd4});
        for (i = 0; i < 150 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (sb.size() != 0 || kif.pressed !== 12'h000)
            $display("FAIL pair_release: got pending=%0d map=%h expected 0/000", sb.size(), kif.pressed);
        else passed++;
    endtask
    task automatic test_backpressure();
        bit ok;
        int i;
        kif.evt_ready = 1'b0;
        held[0] = 1'b1;
        sb.push_back({1'b1, 4'd0});
        for (i = 0; i < 100 && !kif.pressed[0]; i++) begin @(posedge clk); #1; end
        held[1] = 1'b1;
        sb.push_back({1'b1, 4'd1});
        for (i = 0; i < 100 && !kif.pressed[1]; i++) begin @(posedge clk); #1; end
        held[2] = 1'b1;
        sb.push_back({1'b1, 4'd2});
        repeat (80) @(posedge clk);
        #1;
        held[6] = 1'b1;
        sb.push_back({1'b1, 4'd6});
        repeat (80) @(posedge clk);
        #1;
        total++;
        if (kif.pressed !== 12'h003) $display("FAIL stall_map: got %h expected 003", kif.pressed);
        else passed++;
        total++;
        if (kif.evt_valid !== 1'b1 || kif.evt_code !== 4'd0 || kif.evt_press !== 1'b1)
            $display("FAIL stall_head: got valid=%b code=%0d press=%b expected 1/0/1", kif.evt_valid, kif.evt_code, kif.evt_press);
        else passed++;
        wait_row0(ok);
        kif.evt_ready = 1'b1;
        for (i = 0; i < 150 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (!ok || sb.size() != 0 || kif.pressed !== 12'h047)
            $display("FAIL stall_drain: got aligned=%b pending=%0d map=%h expected 1/0/047", ok, sb.size(), kif.pressed);
        else passed++;
    endtask
    task automatic test_enable();
        bit ok;
        logic [3:0] prev, k0;
        prev = kif.keypadr;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            ok = kif.keypadr !== prev;
            prev = kif.keypadr;
        end
        repeat (2) @(posedge clk);
        #1;
        k0 = kif.keypadr;
        en = 1'b0;
        #1;
        total++;
        if (!ok || kif.keypadr !== 4'b0000) $display("FAIL en_off: got aligned=%b rows=%b expected 1/0000", ok, kif.keypadr);
        else passed++;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (kif.keypadr !== 4'b0000 || kif.evt_valid !== 1'b0)
            $display("FAIL en_hold: got rows=%b valid=%b expected 0000/0", kif.keypadr, kif.evt_valid);
        else passed++;
        en = 1'b1;
        #1;
        total++;
        if (kif.keypadr !== k0) $display("FAIL en_resume: got %b expected %b", kif.keypadr, k0);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (kif.keypadr !== k0) $display("FAIL en_same_row: got %b expected %b", kif.keypadr, k0);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (kif.keypadr !== {k0[2:0], k0[3]}) $display("FAIL en_next_row: got %b expected %b", kif.keypadr, {k0[2:0], k0[3]});
        else passed++;
    endtask
    task automatic test_reset_flush();
        int i;
        kif.evt_ready = 1'b0;
        held[0] = 1'b0;
        held[1] = 1'b0;
        for (i = 0; i < 150 && kif.pressed !== 12'h044; i++) begin @(posedge clk); #1; end
        total++;
        if (kif.pressed !== 12'h044 || kif.evt_valid !== 1'b1)
            $display("FAIL queued_events: got map=%h valid=%b expected 044/1", kif.pressed, kif.evt_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (kif.evt_valid !== 1'b0 || kif.pressed !== 12'h000 || kif.evt_code !== 4'd0 || kif.keypadr !== 4'b0001)
            $display("FAIL async_reset: got valid=%b map=%h code=%0d rows=%b expected 0/000/0/0001",
                     kif.evt_valid, kif.pressed, kif.evt_code, kif.keypadr);
        else passed++;
        held = '0;
        kif.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        total++;
        if (kif.evt_valid !== 1'b0 || kif.pressed !== 12'h000)
            $display("FAIL post_reset_idle: got valid=%b map=%h expected 0/000", kif.evt_valid, kif.pressed);
        else passed++;
    endtask
    initial begin
        kif.evt_ready = 1'b1;
        test_reset();
        test_single_key();
        test_glitch();
        test_same_row_pair();
        test_backpressure();
        test_enable();
        test_reset_flush();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
- Parametrised successor to the fixed 3-column/4-row keypad scanner: scans a ROWS x COLS key matrix and debounces each key independently.
- Publishes a debounced key-level map plus a buffered press/release event stream with a valid/ready handshake.
- Sits between the keypad pins and consumers such as the display/hex path or a future command decoder; the top level maps key indices to digits, '*' and '#'.

Parameters:
- ROWS, 4, number of driven matrix rows (>=1)
- COLS, 3, number of sensed matrix columns (>=1)
- SCAN_DIV, 1024, clk cycles each row is driven before sampling (>=2)
- DEBOUNCE, 4, consecutive differing samples required to flip a key's state (>=1)
- FIFO_DEPTH, 4, event buffer entries (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable
- keypadc  in  COLS  column sense, active-high (board pull-downs), asynchronous to clk
- keypadr  out  ROWS  row drive, one-hot active-high
- pressed  out  ROWS*COLS  debounced level map, bit k = row*COLS+col
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts the event
- evt_code  out  KW  key index of the head event, KW = clog2(ROWS*COLS)
- evt_press  out  1  1 = press, 0 = release

Behaviour:
- Reset, asynchronous: row index 0, prescaler 0, all debounce counters 0, pressed = 0, FIFO empty (evt_valid = 0; evt_code and evt_press = 0).
- keypadr = en ? (1 << row) : 0, decoded from the registered row index. With en = 1 after reset, keypadr = 1.
- keypadc passes through a 2-flop synchroniser before any use.
- Prescaler counts 0..SCAN_DIV-1 while en = 1. On the terminal count ("tick"):
  - the synchronised columns are sampled for the current row;
  - the row index advances, wrapping from ROWS-1 to 0.
- Per-key debounce, evaluated only for the sampled row on a tick:
  - sample == pressed[k]: counter[k] <= 0.
  - sample != pressed[k]: counter[k] increments, saturating at DEBOUNCE.
  - When counter[k] reaches DEBOUNCE, the key is flip-eligible.
- Commit of flip-eligible keys:
  - At most one commit per tick; the lowest column index wins.
  - A commit toggles pressed[k], clears counter[k], and pushes {press = new pressed[k], code = k}.
  - A commit requires FIFO space. Pop and push in the same cycle count as space even when the FIFO is full.
  - A losing or space-blocked key keeps its counter saturated and retries on the next tick for that row, if its sample still differs. No event is ever dropped, and the event stream always reconstructs pressed exactly.
- Latency: a cleanly pressed key sets pressed[k] and evt_valid within DEBOUNCE*ROWS*SCAN_DIV + SCAN_DIV + 3 cycles.
- Glitch rejection: a glitch seen in fewer than DEBOUNCE consecutive row samples produces no change.
- FIFO behaviour:
  - First-word-fall-through: evt_code and evt_press are valid whenever evt_valid = 1.
  - Pop on evt_valid && evt_ready.
  - evt_valid rises the cycle after a push into an empty FIFO.
  - The head must hold stable while evt_valid && !evt_ready.
- en = 0:
  - prescaler, row index and debounce counters hold;
  - keypadr = 0;
  - FIFO pops continue;
  - resuming with en = 1 continues from the held state.
- Reset mid-scan or with a non-empty FIFO: everything returns to the reset state immediately; buffered events are discarded.

Decomposition:
- Package keypad_pkg holds:
  - a width function for KW;
  - the event record {press, code}, with its packed width;
  - key-index helpers (row*COLS+col).
- One sub-module: keypad_evt_fifo, a parametrised FWFT FIFO with push/full and pop/valid ports. Reusable by other event sources.
- Scanner, synchroniser and debounce stay in keypad_matrix_scan.

Test Plan (ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=2, evt_ready=1 unless stated):
- Reset, en=1 -> keypadr = 0001, advancing every 4 cycles: 0010, 0100, 1000, 0001; pressed = 0; evt_valid = 0.
- Hold key 5 (row 1, col 2) closed -> after its third row-1 sample, pressed[5] = 1 and one event {press=1, code=5}. Release -> {press=0, code=5}.
- Key 0 closed for only 2 row-0 samples, then open -> no event; pressed[0] stays 0.
- Keys 3 and 4 pressed in the same cycle -> event code 3 first. Code 4 follows exactly one ROWS*SCAN_DIV = 16 cycles later.
- evt_ready = 0, press keys 0, 1, 2 and 6 in turn:
  - FIFO holds codes 0, 1; later flips stall with no loss;
  - pressed shows only bits 0 and 1;
  - raising evt_ready yields 0, 1, 2, 6 in order, and pressed ends at 0x047.
- en dropped mid-scan for 20 cycles -> keypadr = 0 and the row index holds, resuming at the same row. Asserting rst_n = 0 with 2 events queued -> evt_valid = 0 immediately.
